flit_buffer: RTL and testbench
==============================

Name: flit_buffer

Overview:
- Parametrised per-input-port flit FIFO for the NoC router: circular buffer, FLIT_WIDTH-bit cells, arbitrary DEPTH.
- Supports concurrent read and write in the same cycle, and provides an occupancy count and an almost-full flag for credit/flow control.
- Sits between the link input and the route-compute/VC-allocation stages.
- Show-ahead read: head flit is always visible on data_o.

Parameters:
- FLIT_WIDTH, 16, width of one flit in bits (≥1).
- DEPTH, 8, number of flit cells (≥2; need not be a power of two).
- ALMOST_FULL_TH, 6, occupancy at or above which almost_full_o asserts (1..DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_i  in  FLIT_WIDTH  flit to enqueue.
- write_i  in  1  enqueue request.
- read_i  in  1  dequeue request (head flit consumed at this edge).
- data_o  out  FLIT_WIDTH  head flit, combinational from memory[read_ptr].
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- almost_full_o  out  1  count >= ALMOST_FULL_TH.
- count_o  out  CNT_W  current occupancy; CNT_W = clog2(DEPTH+1).

Behaviour:
- State:
  - read_ptr and write_ptr, PTR_W = max(1, clog2(DEPTH)) bits.
  - count, CNT_W bits.
  - memory[DEPTH][FLIT_WIDTH], not reset.
- Reset (rst=1 at posedge): read_ptr=0, write_ptr=0, count=0.
  - Outputs become empty_o=1, full_o=0, almost_full_o=0, count_o=0.
  - rst overrides read_i/write_i; no memory write that cycle.
  - Reset mid-operation discards all contents.
- Flags are decoded combinationally from the registered count. No flag lags the count.
- Accept rules:
  - wr_ok = write_i & (~full_o | read_i).
  - rd_ok = read_i & ~empty_o.
- Pointer advance: on wr_ok, memory[write_ptr]<=data_i; write_ptr advances. On rd_ok, read_ptr advances.
- Wrap-around: ptr==DEPTH-1 -> 0, otherwise ptr+1. There is no reliance on power-of-two rollover.
- Count: count += wr_ok - rd_ok. Both accepted -> count unchanged.
- Boundary cases:
  - Empty, read+write: write accepted, read ignored (no bypass). count 0->1. data_o shows the new flit next cycle.
  - Full, read+write: both accepted. The written slot is the one vacated; the read flit was already presented on data_o this cycle. count stays DEPTH.
  - Full, write only: write dropped, no state change.
  - Empty, read only: read ignored, no state change.
- data_o is don't-care while empty_o=1.
- Latency: a written flit is visible on data_o one cycle after the write edge, if it is the head.

Optional Feature:
- Macro FLIT_BUFFER_ERR_EN.
- When defined:
  - Extra ports overflow_o and underflow_o (out, 1 bit each), sticky, cleared only by rst.
  - overflow_o sets at the edge where write_i & full_o & ~read_i.
  - underflow_o sets at the edge where read_i & empty_o.
- When undefined: the ports and logic are absent, and drops are silent.
- Core behaviour is identical in both builds.

Decomposition:
- Shared package noc_params: default FLIT_WIDTH, buffer DEPTH, the clog2 function, and flit typedef flit_t.
- No sub-module. Pointer increment is a local function ptr_inc(ptr) with explicit wrap. Single module.

Test Plan:
- Reset then write flits 0xA001..0xA008 (DEPTH=8), no reads:
  - count_o goes 1..8; almost_full_o rises when count reaches 6; full_o=1 after the 8th.
  - A 9th write (0xDEAD) is dropped; the ERR_EN build sets overflow_o.
- Drain 8 reads from full:
  - data_o sequence A001..A008 in order; empty_o=1 after the 8th.
  - A further read leaves pointers unchanged; the ERR_EN build sets underflow_o.
- DEPTH=5, 13 single write/read pairs (not simultaneous):
  - Pointers wrap 4->0 correctly; all 13 flits returned in order.
- Full (DEPTH=8), read+write 0xB000..0xB00F for 16 cycles:
  - count_o stays 8, full_o stays 1; output order is the old 8 flits then B000..B007.
- Empty, read+write 0xC001 in the same cycle:
  - count_o=1, empty_o=0 next cycle, data_o=0xC001.
- Fill 3 flits, assert rst for one cycle together with write_i:
  - count_o=0, empty_o=1, flags cleared; the flit presented with rst is not stored.

Source files
------------

// File: rtl/noc_params_pkg.sv
// Shared NoC router parameters: default flit width, default buffer depth,
// the flit type and a constant-evaluable ceil(log2) helper.
package noc_params;

  localparam int NOC_FLIT_WIDTH = 16;
  localparam int NOC_BUF_DEPTH  = 8;

  typedef logic [NOC_FLIT_WIDTH-1:0] flit_t;

  // ceil(log2(value)); returns 0 for value <= 1. Usable in parameter context.
  function automatic int noc_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/flit_buffer.sv
// Per-input-port flit FIFO for the NoC router.
// Circular buffer of DEPTH cells (any DEPTH >= 2), show-ahead head on data_o,
// occupancy count plus full/empty/almost-full flags for credit flow control.
// Optional build macro FLIT_BUFFER_ERR_EN adds sticky overflow_o/underflow_o.
module flit_buffer
  import noc_params::*;
#(
  parameter int FLIT_WIDTH     = NOC_FLIT_WIDTH,
  parameter int DEPTH          = NOC_BUF_DEPTH,
  parameter int ALMOST_FULL_TH = 6,
  localparam int CNT_W         = noc_clog2(DEPTH + 1),
  localparam int PTR_W         = (noc_clog2(DEPTH) > 1) ? noc_clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] data_i,
  input  logic                  write_i,
  input  logic                  read_i,
  output logic [FLIT_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic [CNT_W-1:0]      count_o
`ifdef FLIT_BUFFER_ERR_EN
  ,
  output logic                  overflow_o,
  output logic                  underflow_o
`endif
);

  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // Explicit wrap so non-power-of-two depths never step past the last cell.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  // Flags decode straight from the registered count so none of them lags it.
  // A write into a full buffer is allowed when the head is leaving the same
  // cycle; a read of an empty buffer is never allowed (no bypass path).
  always_comb begin
    w_full  = (r_count == CNT_W'(DEPTH));
    w_empty = (r_count == '0);
    w_wr_ok = write_i & (~w_full | read_i);
    w_rd_ok = read_i & ~w_empty;
  end

  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign almost_full_o = (r_count >= CNT_W'(ALMOST_FULL_TH));
  assign count_o       = r_count;
  assign data_o        = r_mem[r_rd_ptr];

  // Pointer and occupancy update; reset wins over any request that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_wr_ok && w_rd_ok) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Flit storage: not reset, and never written while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

`ifdef FLIT_BUFFER_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error capture of refused requests; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write_i & w_full & ~read_i) begin
        r_overflow <= 1'b1;
      end
      if (read_i & w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;
`else
  // Without error reporting, refused writes and reads are dropped silently.
`endif

endmodule

// File: tb/tb_flit_buffer.sv
// Testbench for flit_buffer: one DEPTH=8 instance and one DEPTH=5 instance.
// Data is checked by scoreboard queues filled at stimulus time and popped by
// per-instance monitors on every accepted read; status is checked directly.
module tb_flit_buffer;
  import noc_params::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=8 instance signals
  logic        rst8 = 1'b1, wr8 = 1'b0, rd8 = 1'b0;
  logic [15:0] di8 = '0, do8;
  logic        full8, empty8, af8;
  logic [3:0]  cnt8;
  // DEPTH=5 instance signals
  logic        rst5 = 1'b1, wr5 = 1'b0, rd5 = 1'b0;
  logic [15:0] di5 = '0, do5;
  logic        full5, empty5, af5;
  logic [2:0]  cnt5;
`ifdef FLIT_BUFFER_ERR_EN
  logic ov8, un8, ov5, un5;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] q8[$];
  logic [15:0] q5[$];

  flit_buffer #(.FLIT_WIDTH(16), .DEPTH(8), .ALMOST_FULL_TH(6)) u8 (
    .clk(clk), .rst(rst8), .data_i(di8), .write_i(wr8), .read_i(rd8),
    .data_o(do8), .full_o(full8), .empty_o(empty8), .almost_full_o(af8),
    .count_o(cnt8)
`ifdef FLIT_BUFFER_ERR_EN
    , .overflow_o(ov8), .underflow_o(un8)
`endif
  );

  flit_buffer #(.FLIT_WIDTH(16), .DEPTH(5), .ALMOST_FULL_TH(4)) u5 (
    .clk(clk), .rst(rst5), .data_i(di5), .write_i(wr5), .read_i(rd5),
    .data_o(do5), .full_o(full5), .empty_o(empty5), .almost_full_o(af5),
    .count_o(cnt5)
`ifdef FLIT_BUFFER_ERR_EN
    , .overflow_o(ov5), .underflow_o(un5)
`endif
  );

  // Monitor for the DEPTH=8 instance: compare head flit on every accepted read.
  always @(negedge clk) begin
    logic [15:0] exp;
    if (!rst8 && rd8 && !empty8) begin
      vectors++;
      if (q8.size() == 0) begin
        miscompares++;
        $display("FAIL pop8: data_o=%h, required no read to be accepted", do8);
      end else begin
        exp = q8.pop_front();
        if (do8 !== exp) begin
          miscompares++;
          $display("FAIL pop8: data_o=%h, required %h", do8, exp);
        end else begin
          $display("pop8 data_o=%h ok", do8);
        end
      end
    end
  end

  // Monitor for the DEPTH=5 instance.
  always @(negedge clk) begin
    logic [15:0] exp;
    if (!rst5 && rd5 && !empty5) begin
      vectors++;
      if (q5.size() == 0) begin
        miscompares++;
        $display("FAIL pop5: data_o=%h, required no read to be accepted", do5);
      end else begin
        exp = q5.pop_front();
        if (do5 !== exp) begin
          miscompares++;
          $display("FAIL pop5: data_o=%h, required %h", do5, exp);
        end else begin
          $display("pop5 data_o=%h ok", do5);
        end
      end
    end
  end

  // One clock of stimulus on the DEPTH=8 instance; push = write expected to be accepted.
  task automatic cyc8(input logic w, input logic r, input logic [15:0] d, input logic push);
    wr8 = w; rd8 = r; di8 = d;
    if (push) q8.push_back(d);
    @(posedge clk); #1;
    wr8 = 1'b0; rd8 = 1'b0;
  endtask

  task automatic cyc5(input logic w, input logic r, input logic [15:0] d, input logic push);
    wr5 = w; rd5 = r; di5 = d;
    if (push) q5.push_back(d);
    @(posedge clk); #1;
    wr5 = 1'b0; rd5 = 1'b0;
  endtask

  task automatic chk8(input string nm, input logic [3:0] c, input logic f, input logic e, input logic a);
    vectors++;
    if ({cnt8, full8, empty8, af8} !== {c, f, e, a}) begin
      miscompares++;
      $display("FAIL %s: count/full/empty/af=%0d/%b/%b/%b, required %0d/%b/%b/%b",
               nm, cnt8, full8, empty8, af8, c, f, e, a);
    end else begin
      $display("%s: count=%0d full=%b empty=%b af=%b ok", nm, cnt8, full8, empty8, af8);
    end
  endtask

  task automatic chk5(input string nm, input logic [2:0] c, input logic f, input logic e, input logic a);
    vectors++;
    if ({cnt5, full5, empty5, af5} !== {c, f, e, a}) begin
      miscompares++;
      $display("FAIL %s: count/full/empty/af=%0d/%b/%b/%b, required %0d/%b/%b/%b",
               nm, cnt5, full5, empty5, af5, c, f, e, a);
    end else begin
      $display("%s: count=%0d full=%b empty=%b af=%b ok", nm, cnt5, full5, empty5, af5);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", nm, act, req);
    end else begin
      $display("%s: %b ok", nm, act);
    end
  endtask

  initial begin
    // Reset both instances
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b0; rst5 = 1'b0;
    chk8("reset8", 4'd0, 1'b0, 1'b1, 1'b0);
    chk5("reset5", 3'd0, 1'b0, 1'b1, 1'b0);

    // Fill DEPTH=8 with A001..A008
    for (int i = 1; i <= 8; i++) begin
      cyc8(1'b1, 1'b0, 16'hA000 + 16'(i), 1'b1);
      chk8($sformatf("fill%0d", i), 4'(i), (i == 8), 1'b0, (i >= 6));
    end
    // Ninth write is dropped
    cyc8(1'b1, 1'b0, 16'hDEAD, 1'b0);
    chk8("drop_write", 4'd8, 1'b1, 1'b0, 1'b1);
`ifdef FLIT_BUFFER_ERR_EN
    chk_bit("overflow_set", ov8, 1'b1);
`endif

    // Drain 8 reads; monitor checks A001..A008 in order
    for (int j = 1; j <= 8; j++) begin
      cyc8(1'b0, 1'b1, 16'h0, 1'b0);
      chk8($sformatf("drain%0d", j), 4'(8 - j), 1'b0, (j == 8), ((8 - j) >= 6));
    end
    // Read from empty is ignored
    cyc8(1'b0, 1'b1, 16'h0, 1'b0);
    chk8("empty_read", 4'd0, 1'b0, 1'b1, 1'b0);
`ifdef FLIT_BUFFER_ERR_EN
    chk_bit("underflow_set", un8, 1'b1);
`endif

    // Full, simultaneous read+write for 16 cycles
    for (int i = 1; i <= 8; i++) cyc8(1'b1, 1'b0, 16'hA100 + 16'(i), 1'b1);
    chk8("refill", 4'd8, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc8(1'b1, 1'b1, 16'hB000 + 16'(i), 1'b1);
      chk8($sformatf("full_rw%0d", i), 4'd8, 1'b1, 1'b0, 1'b1);
    end
    for (int j = 1; j <= 8; j++) cyc8(1'b0, 1'b1, 16'h0, 1'b0);
    chk8("drain_rw", 4'd0, 1'b0, 1'b1, 1'b0);

    // Empty, read+write same cycle: write only
    cyc8(1'b1, 1'b1, 16'hC001, 1'b1);
    chk8("empty_rw", 4'd1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (do8 !== 16'hC001) begin
      miscompares++;
      $display("FAIL empty_rw_head: data_o=%h, required c001", do8);
    end else begin
      $display("empty_rw_head: data_o=%h ok", do8);
    end
    cyc8(1'b0, 1'b1, 16'h0, 1'b0);

    // Reset mid-operation with a concurrent write
    for (int i = 1; i <= 3; i++) cyc8(1'b1, 1'b0, 16'hD000 + 16'(i), 1'b1);
    chk8("pre_rst", 4'd3, 1'b0, 1'b0, 1'b0);
    rst8 = 1'b1;
    q8.delete();
    cyc8(1'b1, 1'b0, 16'hEEEE, 1'b0);
    rst8 = 1'b0;
    chk8("mid_rst", 4'd0, 1'b0, 1'b1, 1'b0);
`ifdef FLIT_BUFFER_ERR_EN
    chk_bit("overflow_clr", ov8, 1'b0);
    chk_bit("underflow_clr", un8, 1'b0);
`endif
    cyc8(1'b1, 1'b0, 16'hF001, 1'b1);
    chk8("post_rst_wr", 4'd1, 1'b0, 1'b0, 1'b0);
    cyc8(1'b0, 1'b1, 16'h0, 1'b0);
    chk8("post_rst_rd", 4'd0, 1'b0, 1'b1, 1'b0);

    // DEPTH=5: 13 write/read pairs exercise pointer wrap 4->0
    for (int i = 1; i <= 13; i++) begin
      cyc5(1'b1, 1'b0, 16'h5000 + 16'(i), 1'b1);
      cyc5(1'b0, 1'b1, 16'h0, 1'b0);
    end
    chk5("pairs5", 3'd0, 1'b0, 1'b1, 1'b0);
    // DEPTH=5 fill to full at a non-power-of-two depth, then drain
    for (int i = 1; i <= 5; i++) begin
      cyc5(1'b1, 1'b0, 16'h5100 + 16'(i), 1'b1);
      chk5($sformatf("fill5_%0d", i), 3'(i), (i == 5), 1'b0, (i >= 4));
    end
    cyc5(1'b1, 1'b0, 16'hDEAD, 1'b0);
    chk5("drop5", 3'd5, 1'b1, 1'b0, 1'b1);
    for (int j = 1; j <= 5; j++) cyc5(1'b0, 1'b1, 16'h0, 1'b0);
    chk5("drain5", 3'd0, 1'b0, 1'b1, 1'b0);

    // Every expected flit must have been returned
    @(posedge clk); #1;
    vectors++;
    if (q8.size() != 0) begin
      miscompares++;
      $display("FAIL q8_left: %0d flits not returned, required 0", q8.size());
    end
    vectors++;
    if (q5.size() != 0) begin
      miscompares++;
      $display("FAIL q5_left: %0d flits not returned, required 0", q5.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
